// File: rtl/texture_fetch_arbiter_if.sv
// Bundle of request, ROM and response signals shared between the texture
// fetch arbiter and the blocks around it (requesters and texture ROM).
interface texture_fetch_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [5:0] req0_texture_idx;
   logic [2:0] req0_y;
   logic [2:0] req0_x;

   logic       req1_valid;
   logic       req1_ready;
   logic [5:0] req1_texture_idx;
   logic [2:0] req1_y;
   logic [2:0] req1_x;

   logic [5:0] rom_texture_idx;
   logic [2:0] rom_y_idx;
   logic [2:0] rom_x_idx;
   logic [3:0] rom_val;

   logic       rsp0_valid;
   logic       rsp1_valid;
   logic [3:0] rsp_data;
   logic       busy;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_texture_idx, req0_y, req0_x,
      input  req1_valid, req1_texture_idx, req1_y, req1_x,
      input  rom_val,
      output req0_ready, req1_ready,
      output rom_texture_idx, rom_y_idx, rom_x_idx,
      output rsp0_valid, rsp1_valid, rsp_data, busy
   );

   // Requester / ROM side
   modport master (
      output req0_valid, req0_texture_idx, req0_y, req0_x,
      output req1_valid, req1_texture_idx, req1_y, req1_x,
      output rom_val,
      input  req0_ready, req1_ready,
      input  rom_texture_idx, rom_y_idx, rom_x_idx,
      input  rsp0_valid, rsp1_valid, rsp_data, busy
   );
endinterface

// File: rtl/texture_fetch_arbiter.sv
// Texture fetch arbiter: shares the single-port, one-cycle texture ROM
// between the mode7 floor renderer (requester 0) and the sprite fetcher
// (requester 1). One fetch per clock, responses two cycles after the grant,
// tagged back to the requester that issued them.
module texture_fetch_arbiter #(
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   texture_fetch_arbiter_if.slave  bus
);

   logic       w_grant0;
   logic       w_grant1;
   logic       w_grantAny;
   logic [5:0] w_selTex;
   logic [2:0] w_selY;
   logic [2:0] w_selX;

   logic       r_lastGrant;
   logic [5:0] r_romTex;
   logic [2:0] r_romY;
   logic [2:0] r_romX;
   logic       r_s1Valid;
   logic       r_s1Tag;
   logic       r_s2Valid;
   logic       r_s2Tag;

   // Grant decision: a lone requester always wins; on a tie round-robin
   // picks whoever did not win last, fixed priority always picks req0.
   // Nothing is granted while reset is held.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!reset) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (RR_ENABLE && (r_lastGrant == 1'b0)) begin
               w_grant1 = 1'b1;
            end else begin
               w_grant0 = 1'b1;
            end
         end else begin
            w_grant0 = bus.req0_valid;
            w_grant1 = bus.req1_valid;
         end
      end
   end

   assign w_grantAny = w_grant0 | w_grant1;

   // Address mux selecting the winner's coordinates for the ROM register.
   always_comb begin
      w_selTex = bus.req0_texture_idx;
      w_selY   = bus.req0_y;
      w_selX   = bus.req0_x;
      if (w_grant1) begin
         w_selTex = bus.req1_texture_idx;
         w_selY   = bus.req1_y;
         w_selX   = bus.req1_x;
      end
   end

   // Remember the last winner; starts at 1 so req0 takes the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lastGrant <= 1'b1;
      end else if (w_grantAny) begin
         r_lastGrant <= w_grant1;
      end
   end

   // ROM address register; holds its value when idle so the bus stays quiet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_romTex <= '0;
         r_romY   <= '0;
         r_romX   <= '0;
      end else if (w_grantAny) begin
         r_romTex <= w_selTex;
         r_romY   <= w_selY;
         r_romX   <= w_selX;
      end
   end

   // Two-stage valid/tag pipeline tracking which requester owns the data
   // coming out of the ROM; reset drops anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1Valid <= 1'b0;
         r_s1Tag   <= 1'b0;
         r_s2Valid <= 1'b0;
         r_s2Tag   <= 1'b0;
      end else begin
         r_s1Valid <= w_grantAny;
         r_s1Tag   <= w_grant1;
         r_s2Valid <= r_s1Valid;
         r_s2Tag   <= r_s1Tag;
      end
   end

   assign bus.req0_ready      = w_grant0;
   assign bus.req1_ready      = w_grant1;
   assign bus.rom_texture_idx = r_romTex;
   assign bus.rom_y_idx       = r_romY;
   assign bus.rom_x_idx       = r_romX;
   assign bus.rsp0_valid      = r_s2Valid & ~r_s2Tag;
   assign bus.rsp1_valid      = r_s2Valid & r_s2Tag;
   assign bus.rsp_data        = reset ? 4'h0 : bus.rom_val;
   assign bus.busy            = r_s1Valid | r_s2Valid;

endmodule
